// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - multi-cycle 32x32->64 multiply sequencer using the shared add/sub unit
// Shift-add on magnitudes with pre-negation of operands and post-negation of the 64-bit product.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, MUL, NEG_LO, NEG_HI, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rs_q, rt_q, mcand;
  logic             sgn_q, neg, lo_zero, carry;
  logic [4:0]       cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_op    = OP_ADD;
    alu_a     = '0;
    alu_b     = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ABS_A;
      end
      ABS_A: begin
        alu_op    = OP_SUB;
        alu_b     = rs_q;
        state_nxt = ABS_B;
      end
      ABS_B: begin
        alu_op    = OP_SUB;
        alu_b     = rt_q;
        state_nxt = MUL;
      end
      MUL: begin
        alu_a = hi;
        alu_b = lo[0] ? mcand : '0;
        if (cnt == 5'd31) state_nxt = NEG_LO;
      end
      NEG_LO: begin
        alu_op    = OP_SUB;
        alu_b     = lo;
        state_nxt = NEG_HI;
      end
      NEG_HI: begin
        alu_a     = ~hi;
        alu_b     = {{(WIDTH-1){1'b0}}, lo_zero};
        state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = start ? ABS_A : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Carry out of the unsigned add, recovered from operand and result MSBs.
  assign carry = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                 ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_result[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rs_q    <= '0;
      rt_q    <= '0;
      sgn_q   <= 1'b0;
      neg     <= 1'b0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      lo_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            rs_q  <= rs;
            rt_q  <= rt;
            sgn_q <= is_signed;
            neg   <= is_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
          end
        end
        ABS_A: mcand <= (sgn_q & rs_q[WIDTH-1]) ? alu_result : rs_q;
        ABS_B: begin
          lo  <= (sgn_q & rt_q[WIDTH-1]) ? alu_result : rt_q;
          hi  <= '0;
          cnt <= '0;
        end
        MUL: begin
          hi  <= {carry, alu_result[WIDTH-1:1]};
          lo  <= {alu_result[0], lo[WIDTH-1:1]};
          cnt <= cnt + 5'd1;
        end
        NEG_LO: begin
          lo_zero <= alu_z;
          if (neg) lo <= alu_result;
        end
        NEG_HI: begin
          if (neg) hi <= alu_result;
        end
        default: ;
      endcase
    end
  end

endmodule
